// File: rtl/pll_seq_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Holds the FSM state encoding and the counter-sizing helper.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      HOLD      = 3'd3,
      RUN       = 3'd4
   } state_e;

   localparam int unsigned DEF_PLL_RST_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT   = 65536;
   localparam int unsigned DEF_LOCK_STABLE    = 1024;
   localparam int unsigned DEF_RESET_HOLD     = 64;
   localparam int unsigned DEF_CNT_W          = 8;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-high clear.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse, lock wait with timeout/retry, lock debounce and system reset release.
// Outputs are registered from the next state so they move on the same edge as the state.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int unsigned LOCK_STABLE    = DEF_LOCK_STABLE,
   parameter int unsigned RESET_HOLD     = DEF_RESET_HOLD,
   parameter int unsigned CNT_W          = DEF_CNT_W
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             locked,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [2:0]       state_o
);

   localparam int unsigned CMAX = max4(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, RESET_HOLD);
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             pll_rst_q, sys_rst_q, ready_q;
   logic [CNT_W-1:0] loss_q, retry_q;
   logic             locked_s;
   logic             retry_inc, loss_inc;

   sync_2ff u_lock_sync (
      .clk_i (refclk),
      .rst_i (rst),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      retry_inc = 1'b0;
      loss_inc  = 1'b0;
      case (state_q)
         PLL_RESET: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            // lock takes priority over a timeout landing on the same cycle
            if (locked_s) begin
               state_d = STABILIZE;
            end else if (cnt_q == TO_LAST) begin
               state_d   = PLL_RESET;
               retry_inc = 1'b1;
            end
         end
         STABILIZE: begin
            if (!locked_s)                state_d = WAIT_LOCK;
            else if (cnt_q == STB_LAST)   state_d = HOLD;
         end
         HOLD: begin
            if (!locked_s)                state_d = WAIT_LOCK;
            else if (cnt_q == HOLD_LAST)  state_d = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_d  = WAIT_LOCK;
               loss_inc = 1'b1;
            end
         end
         default: state_d = PLL_RESET;
      endcase
      // counter parks at zero in RUN so it can never overflow there
      if (state_d != state_q || state_q == RUN) cnt_d = '0;
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= PLL_RESET;
         cnt_q     <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         loss_q    <= '0;
         retry_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pll_rst_q <= (state_d == PLL_RESET);
         sys_rst_q <= (state_d != RUN);
         ready_q   <= (state_d == RUN);
         if (retry_inc && retry_q != '1) retry_q <= retry_q + CNT_W'(1);
         if (loss_inc && loss_q != '1)   loss_q  <= loss_q + CNT_W'(1);
      end
   end

   assign pll_rst       = pll_rst_q;
   assign sys_rst       = sys_rst_q;
   assign ready         = ready_q;
   assign lock_loss_cnt = loss_q;
   assign retry_cnt     = retry_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomized scoreboard bench for pll_reset_sequencer with a phase/age reference model.
module tb_pll_reset_sequencer;

   localparam int unsigned P_RST  = 4;
   localparam int unsigned P_TO   = 100;
   localparam int unsigned P_STB  = 8;
   localparam int unsigned P_HOLD = 5;
   localparam int unsigned P_CW   = 8;
   localparam int          SAT    = 255;

   logic            refclk = 1'b0;
   logic            rst    = 1'b1;
   logic            locked = 1'b0;
   logic            pll_rst, sys_rst, ready;
   logic [P_CW-1:0] lock_loss_cnt, retry_cnt;
   logic [2:0]      state_o;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES (P_RST),
      .LOCK_TIMEOUT   (P_TO),
      .LOCK_STABLE    (P_STB),
      .RESET_HOLD     (P_HOLD),
      .CNT_W          (P_CW)
   ) dut (
      .refclk        (refclk),
      .rst           (rst),
      .locked        (locked),
      .pll_rst       (pll_rst),
      .sys_rst       (sys_rst),
      .ready         (ready),
      .lock_loss_cnt (lock_loss_cnt),
      .retry_cnt     (retry_cnt),
      .state_o       (state_o)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      int pll;
      int sys;
      int rdy;
      int st;
      int loss;
      int retry;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 0;

   // reference model: phase index, edges spent in phase, locked history
   int phase = 0, age = 0, m_loss = 0, m_retry = 0;
   int hist1 = 0, hist2 = 0;
   int dur[4] = '{P_RST, P_TO, P_STB, P_HOLD};

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, expv, $time);
      end
   endtask

   function automatic void enter(input int p);
      phase = p;
      age   = 0;
   endfunction

   function automatic void model_edge(input int r, input int l);
      int ls;
      if (r != 0) begin
         phase = 0; age = 0; m_loss = 0; m_retry = 0; hist1 = 0; hist2 = 0;
         return;
      end
      ls    = hist2;
      hist2 = hist1;
      hist1 = l;
      age++;
      if (phase == 0) begin
         if (age == dur[0]) enter(1);
      end else if (phase == 1) begin
         if (ls != 0) enter(2);
         else if (age == dur[1]) begin
            enter(0);
            if (m_retry < SAT) m_retry++;
         end
      end else if (phase == 4) begin
         if (ls == 0) begin
            enter(1);
            if (m_loss < SAT) m_loss++;
         end
      end else begin
         if (ls == 0) enter(1);
         else if (age == dur[phase]) enter(phase + 1);
      end
   endfunction

   task automatic step(input int r, input int l);
      exp_t e;
      @(negedge refclk);
      rst    = r[0];
      locked = l[0];
      model_edge(r, l);
      e.pll   = (phase == 0) ? 1 : 0;
      e.sys   = (phase == 4) ? 0 : 1;
      e.rdy   = (phase == 4) ? 1 : 0;
      e.st    = phase;
      e.loss  = m_loss;
      e.retry = m_retry;
      q.push_back(e);
   endtask

   task automatic hold(input int n, input int l);
      for (int i = 0; i < n; i++) step(0, l);
   endtask

   // monitor: compares one expected record against every sampled output edge
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge refclk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pll_rst", int'(pll_rst), e.pll);
            chk("sys_rst", int'(sys_rst), e.sys);
            chk("ready", int'(ready), e.rdy);
            chk("state_o", int'(state_o), e.st);
            chk("lock_loss_cnt", int'(lock_loss_cnt), e.loss);
            chk("retry_cnt", int'(retry_cnt), e.retry);
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < 3; i++) step(1, 0);
      // no lock at all: two timeouts and retries
      hold(230, 0);
      // lock arrives and stays
      hold(int'($urandom_range(1, 20)), 0);
      hold(40, 1);
      // debounce glitches
      for (int i = 0; i < 20; i++) begin
         hold(int'($urandom_range(1, 14)), 1);
         hold(int'($urandom_range(1, 4)), 0);
      end
      hold(30, 1);
      // repeated lock loss in RUN drives the loss counter into saturation
      for (int i = 0; i < 300; i++) begin
         hold(int'($urandom_range(1, 3)), 0);
         hold(24, 1);
      end
      @(posedge refclk);
      #2;
      chk("loss_saturated", int'(lock_loss_cnt), SAT);
      // one-cycle reset from RUN, then the sequence replays
      step(1, 1);
      hold(40, 1);
      // random mix with occasional reset and timeouts
      for (int i = 0; i < 60; i++) begin
         n = int'($urandom_range(1, 120));
         if ($urandom_range(0, 9) == 0) step(1, int'($urandom_range(0, 1)));
         hold(n, int'($urandom_range(0, 1)));
      end
      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge refclk);
         n++;
      end
      #3;
      if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
      done = 1;
      @(posedge refclk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
